hack_data_mem: RTL and testbench

- Responder end of the CPU data-memory port. It consumes the CPU's addrM, outM and WriteM, and returns inM combinationally in the same cycle.
- Decodes the address space as follows:
  - data RAM;
  - a write-only screen window, forwarded to the display side through a small FIFO with a valid/ready handshake;
  - a keyboard register, filled from the keyboard side with a valid/ack handshake;
  - a status register.
- Sits between the cpu and the peripherals, replacing an ad-hoc RAM + mux.

---
 rtl/hack_mem_pkg.sv | 36 +++
 rtl/scr_fifo.sv | 60 ++++++
 rtl/hack_data_mem.sv | 110 +++++++++++
 tb/tb_hack_data_mem.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - address map constants and region decode for the data-memory port
package hack_mem_pkg;

    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] SCR_BASE    = 16'h4000;
    localparam logic [15:0] SCR_LIMIT   = 16'h5FFF;
    localparam logic [15:0] KBD_ADDR    = 16'h6000;
    localparam logic [15:0] STATUS_ADDR = 16'h6001;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_STAT,
        REG_NONE
    } region_t;

    // RAM occupies the whole lower quarter, so only the top two bits decide it.
    function automatic region_t decode_region(input logic [15:0] addr);
        if (addr[15:14] == RAM_BASE[15:14]) begin
            return REG_RAM;
        end else if (addr >= SCR_BASE && addr <= SCR_LIMIT) begin
            return REG_SCR;
        end else if (addr == KBD_ADDR) begin
            return REG_KBD;
        end else if (addr == STATUS_ADDR) begin
            return REG_STAT;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/scr_fifo.sv
// rtl/scr_fifo.sv - synchronous FIFO carrying screen writes to the display side
module scr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hack_data_mem.sv
// rtl/hack_data_mem.sv - CPU data-memory responder: RAM, screen FIFO, keyboard and status
module hack_data_mem
    import hack_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addrM,
    input  logic [15:0] outM,
    input  logic        WriteM,
    output logic [15:0] inM,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_valid,
    input  logic        scr_ready,
    input  logic [15:0] kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ack
);

    localparam int RAW = $clog2(RAM_WORDS);

    region_t       region;
    logic [15:0]   ram [RAM_WORDS];
    logic [RAW-1:0] ram_idx;
    logic          ram_hit;
    logic [15:0]   kbd_reg;
    logic          kbd_clr;
    logic          kbd_take;
    logic          ovf;
    logic          stat_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [28:0]   fifo_head;
    logic [15:0]   status;

    assign region   = decode_region(addrM);
    assign ram_idx  = addrM[RAW-1:0];
    assign ram_hit  = (region == REG_RAM) && ({1'b0, addrM[13:0]} < 15'(RAM_WORDS));
    assign kbd_clr  = WriteM && (region == REG_KBD);
    // A CPU clear beats a same-cycle capture; the source is still holding and retries next cycle.
    assign kbd_take = kbd_valid && (kbd_reg == '0) && !kbd_clr;
    assign stat_clr = WriteM && (region == REG_STAT);

    scr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (29)
    ) u_scr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (WriteM && (region == REG_SCR)),
        .push_data ({addrM[12:0], outM}),
        .pop       (scr_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign scr_valid = !fifo_empty;
    assign scr_addr  = fifo_head[28:16];
    assign scr_data  = fifo_head[15:0];

    always_ff @(posedge clk) begin
        if (WriteM && ram_hit) begin
            ram[ram_idx] <= outM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kbd_reg <= '0;
            kbd_ack <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            kbd_ack <= kbd_take;
            if (kbd_clr) begin
                kbd_reg <= '0;
            end else if (kbd_take) begin
                kbd_reg <= kbd_data;
            end
            if (fifo_drop) begin
                ovf <= 1'b1;
            end else if (stat_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_OVF]   = ovf;
    end

    always_comb begin
        inM = '0;
        case (region)
            REG_RAM:  if (ram_hit) inM = ram[ram_idx];
            REG_KBD:  inM = kbd_reg;
            REG_STAT: inM = status;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_hack_data_mem.sv
// tb/tb_hack_data_mem.sv - randomized self-checking bench for hack_data_mem
module tb_hack_data_mem;

    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addrM;
    logic [15:0] outM;
    logic        WriteM;
    logic [15:0] inM;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_valid;
    logic        scr_ready;
    logic [15:0] kbd_data;
    logic        kbd_valid;
    logic        kbd_ack;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_ram [int];
    logic [28:0] m_q [$];
    logic        m_ovf;
    logic [15:0] m_kbd;
    logic        m_ack;

    hack_data_mem #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addrM     (addrM),
        .outM      (outM),
        .WriteM    (WriteM),
        .inM       (inM),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_valid (scr_valid),
        .scr_ready (scr_ready),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ack   (kbd_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'h4000) begin
            if (int'(a) < RAM_WORDS && m_ram.exists(int'(a))) return m_ram[int'(a)];
            return 16'h0000;
        end
        if (a <= 16'h5FFF) return 16'h0000;
        if (a == 16'h6000) return m_kbd;
        if (a == 16'h6001) return {13'b0, m_ovf, (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_kbd = 16'h0000;
        m_ack = 1'b0;
    endtask

    // Advances one clock, applying the current inputs to the reference model.
    task automatic step();
        bit pop, push, ovf_now, kclr;
        pop     = (m_q.size() > 0) && scr_ready;
        push    = WriteM && addrM >= 16'h4000 && addrM <= 16'h5FFF;
        ovf_now = push && (m_q.size() == FIFO_DEPTH) && !pop;
        kclr    = WriteM && addrM == 16'h6000;
        m_ack   = !kclr && kbd_valid && (m_kbd == 16'h0000);
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push && !ovf_now) m_q.push_back({addrM[12:0], outM});
        if (ovf_now) m_ovf = 1'b1;
        else if (WriteM && addrM == 16'h6001) m_ovf = 1'b0;
        if (kclr) m_kbd = 16'h0000;
        else if (m_ack) m_kbd = kbd_data;
        if (WriteM && addrM < 16'h4000 && int'(addrM) < RAM_WORDS) m_ram[int'(addrM)] = outM;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; addrM = 16'h6001; outM = 16'h0; WriteM = 1'b0;
        scr_ready = 1'b0; kbd_data = 16'h0; kbd_valid = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (scr_valid !== 1'b0) begin errors++; $display("FAIL reset_scr_valid got=%b exp=0", scr_valid); end
        checks++;
        if (kbd_ack !== 1'b0) begin errors++; $display("FAIL reset_kbd_ack got=%b exp=0", kbd_ack); end
        checks++;
        if (inM !== 16'h0001) begin errors++; $display("FAIL reset_status got=%h exp=0001", inM); end
        addrM = 16'h6000; #1;
        checks++;
        if (inM !== 16'h0000) begin errors++; $display("FAIL reset_kbd_reg got=%h exp=0000", inM); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram();
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            addrM = 16'(i); outM = 16'($urandom); WriteM = 1'b1; step();
        end
        WriteM = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addrM = 16'(i); #1;
            checks++;
            if (inM !== model_read(addrM)) begin errors++; $display("FAIL ram_fill addr=%h got=%h exp=%h", addrM, inM, model_read(addrM)); end
        end
        addrM = 16'h0005; outM = 16'h1111; WriteM = 1'b1; step();
        outM = 16'h1234; #1;
        checks++;
        if (inM !== 16'h1111) begin errors++; $display("FAIL ram_same_cycle got=%h exp=1111", inM); end
        step(); WriteM = 1'b0; #1;
        checks++;
        if (inM !== 16'h1234) begin errors++; $display("FAIL ram_rd5 got=%h exp=1234", inM); end
        addrM = 16'h0800; outM = 16'hBEEF; WriteM = 1'b1; step(); WriteM = 1'b0; #1;
        checks++;
        if (inM !== 16'h0000) begin errors++; $display("FAIL ram_unimpl got=%h exp=0000", inM); end
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0400, 16'h3FFF)) : 16'($urandom_range(0, 15));
            addrM = a; outM = 16'($urandom); WriteM = 1'($urandom_range(0, 1)); #1;
            checks++;
            if (inM !== model_read(a)) begin errors++; $display("FAIL ram_rand addr=%h got=%h exp=%h", a, inM, model_read(a)); end
            step();
        end
        WriteM = 1'b0;
    endtask

    task automatic test_screen_fifo();
        logic [28:0] exp_e [3];
        exp_e[0] = {13'h0000, 16'hAAAA};
        exp_e[1] = {13'h0001, 16'h5555};
        exp_e[2] = {13'h1FFF, 16'hFFFF};
        scr_ready = 1'b0; WriteM = 1'b1;
        addrM = 16'h4000; outM = 16'hAAAA; step();
        addrM = 16'h4001; outM = 16'h5555; step();
        addrM = 16'h5FFF; outM = 16'hFFFF; step();
        WriteM = 1'b0; addrM = 16'h4001; #1;
        checks++;
        if (inM !== 16'h0000) begin errors++; $display("FAIL scr_read got=%h exp=0000", inM); end
        scr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (scr_valid !== 1'b1 || {scr_addr, scr_data} !== exp_e[i]) begin
                errors++; $display("FAIL scr_order i=%0d got=%b/%h exp=1/%h", i, scr_valid, {scr_addr, scr_data}, exp_e[i]);
            end
            step();
        end
        scr_ready = 1'b0; addrM = 16'h6001; #1;
        checks++;
        if (scr_valid !== 1'b0 || inM !== 16'h0001) begin errors++; $display("FAIL scr_drained got=%b/%h exp=0/0001", scr_valid, inM); end
    endtask

    task automatic test_overflow();
        int guard;
        scr_ready = 1'b0; WriteM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addrM = 16'h4000 + 16'($urandom_range(0, 16'h1FFF)); outM = 16'($urandom); step();
        end
        WriteM = 1'b0; addrM = 16'h6001; #1;
        checks++;
        if (inM !== 16'h0006) begin errors++; $display("FAIL ovf_status got=%h exp=0006", inM); end
        WriteM = 1'b1; outM = 16'hFFFF; step(); WriteM = 1'b0; #1;
        checks++;
        if (inM !== 16'h0002) begin errors++; $display("FAIL ovf_clear got=%h exp=0002", inM); end
        scr_ready = 1'b1; WriteM = 1'b1; addrM = 16'h4123; outM = 16'hC0DE; step();
        scr_ready = 1'b0; WriteM = 1'b0; addrM = 16'h6001; #1;
        checks++;
        if (inM !== 16'h0002) begin errors++; $display("FAIL full_push_pop got=%h exp=0002", inM); end
        scr_ready = 1'b1; guard = 0;
        while (m_q.size() > 0 && guard < 10) begin
            checks++;
            if (scr_valid !== 1'b1 || {scr_addr, scr_data} !== m_q[0]) begin
                errors++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", scr_valid, {scr_addr, scr_data}, m_q[0]);
            end
            step(); guard++;
        end
        checks++;
        if (scr_valid !== 1'b0 || guard != 4) begin errors++; $display("FAIL ovf_drain_len got=%0d exp=4", guard); end
        scr_ready = 1'b0;
    endtask

    task automatic test_keyboard();
        kbd_data = 16'h0041; kbd_valid = 1'b1; addrM = 16'h6000; step();
        checks++;
        if (kbd_ack !== 1'b1 || inM !== 16'h0041) begin errors++; $display("FAIL kbd_first got=%b/%h exp=1/0041", kbd_ack, inM); end
        kbd_data = 16'h0042;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (kbd_ack !== 1'b0 || inM !== 16'h0041) begin errors++; $display("FAIL kbd_hold got=%b/%h exp=0/0041", kbd_ack, inM); end
        end
        WriteM = 1'b1; step(); WriteM = 1'b0; #1;
        checks++;
        if (kbd_ack !== 1'b0 || inM !== 16'h0000) begin errors++; $display("FAIL kbd_clear_wins got=%b/%h exp=0/0000", kbd_ack, inM); end
        step();
        checks++;
        if (kbd_ack !== 1'b1 || inM !== 16'h0042) begin errors++; $display("FAIL kbd_second got=%b/%h exp=1/0042", kbd_ack, inM); end
        kbd_valid = 1'b0; step();
        checks++;
        if (kbd_ack !== 1'b0) begin errors++; $display("FAIL kbd_pulse got=%b exp=0", kbd_ack); end
        WriteM = 1'b1; step(); WriteM = 1'b0;
        kbd_data = 16'h0000; kbd_valid = 1'b1; step();
        checks++;
        if (kbd_ack !== 1'b1 || inM !== 16'h0000) begin errors++; $display("FAIL kbd_zero got=%b/%h exp=1/0000", kbd_ack, inM); end
        kbd_valid = 1'b0; step();
    endtask

    task automatic test_async_reset();
        addrM = 16'h6000; WriteM = 1'b1; step(); WriteM = 1'b0;
        kbd_data = 16'h0041; kbd_valid = 1'b1; step(); kbd_valid = 1'b0;
        scr_ready = 1'b0; WriteM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addrM = 16'h4000 + 16'(i); outM = 16'($urandom); step();
        end
        WriteM = 1'b0; scr_ready = 1'b1; step(); step(); scr_ready = 1'b0;
        addrM = 16'h6001; #1;
        checks++;
        if (inM !== 16'h0004 || m_q.size() != 2 || m_kbd !== 16'h0041) begin errors++; $display("FAIL arst_setup got=%h exp=0004", inM); end
        @(posedge clk); #3;
        rst = 1'b0; model_reset(); #1;
        checks++;
        if (scr_valid !== 1'b0 || inM !== 16'h0001) begin errors++; $display("FAIL arst_fifo got=%b/%h exp=0/0001", scr_valid, inM); end
        addrM = 16'h6000; #1;
        checks++;
        if (inM !== 16'h0000 || kbd_ack !== 1'b0) begin errors++; $display("FAIL arst_kbd got=%h/%b exp=0000/0", inM, kbd_ack); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unmapped();
        logic [15:0] addrs [5];
        addrs[0] = 16'h6002; addrs[1] = 16'h7FFF; addrs[2] = 16'h8000;
        addrs[3] = 16'hFFFF; addrs[4] = 16'($urandom_range(16'h6002, 16'hFFFF));
        scr_ready = 1'b0; WriteM = 1'b1; addrM = 16'h4777; outM = 16'h1357; step();
        for (int i = 0; i < 5; i++) begin
            addrM = addrs[i]; outM = 16'h9999; WriteM = 1'b1; step(); WriteM = 1'b0; #1;
            checks++;
            if (inM !== 16'h0000) begin errors++; $display("FAIL unmapped_rd addr=%h got=%h exp=0000", addrM, inM); end
        end
        addrM = 16'h6001; #1;
        checks++;
        if (inM !== model_read(16'h6001) || {scr_addr, scr_data} !== m_q[0]) begin
            errors++; $display("FAIL unmapped_state got=%h/%h exp=%h/%h", inM, {scr_addr, scr_data}, model_read(16'h6001), m_q[0]);
        end
        addrM = 16'h0005; #1;
        checks++;
        if (inM !== 16'h1234) begin errors++; $display("FAIL unmapped_ram got=%h exp=1234", inM); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: addrM = 16'($urandom_range(0, 15));
                4, 5:       addrM = 16'($urandom_range(16'h4000, 16'h5FFF));
                6:          addrM = 16'h6000;
                7:          addrM = 16'h6001;
                8:          addrM = 16'($urandom_range(16'h6002, 16'hFFFF));
                default:    addrM = 16'($urandom_range(16'h0400, 16'h3FFF));
            endcase
            outM = 16'($urandom);
            WriteM = ($urandom_range(0, 2) == 0);
            scr_ready = ($urandom_range(0, 2) == 0);
            if (!kbd_valid && $urandom_range(0, 3) == 0) begin
                kbd_valid = 1'b1; kbd_data = 16'($urandom_range(0, 255));
            end
            #1;
            checks++;
            if (inM !== model_read(addrM)) begin errors++; $display("FAIL rand_inM addr=%h got=%h exp=%h", addrM, inM, model_read(addrM)); end
            checks++;
            if (scr_valid !== (m_q.size() > 0) || (m_q.size() > 0 && {scr_addr, scr_data} !== m_q[0])) begin
                errors++; $display("FAIL rand_scr got=%b/%h exp_count=%0d", scr_valid, {scr_addr, scr_data}, m_q.size());
            end
            step();
            checks++;
            if (kbd_ack !== m_ack) begin errors++; $display("FAIL rand_ack got=%b exp=%b", kbd_ack, m_ack); end
            if (m_ack) kbd_valid = 1'b0;
        end
        WriteM = 1'b0; scr_ready = 1'b0; kbd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_screen_fifo();
        test_overflow();
        test_keyboard();
        test_async_reset();
        test_unmapped();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
